alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Sequencing controller that drives the 32-bit ALU from the other side of its interface.
- Accepts MIPS R-type instructions over a valid/ready handshake and decodes the funct field into the 3-bit ALU select code.
- Reads operands from an internal 32x32 register file, presents them to the ALU, captures ALU_Out and writes the result back to rd.
- Sits between instruction fetch and the ALU in the homework datapath.

Parameters:
- NREGS, 32, number of architectural registers; register 0 is hardwired to zero.
- DW, 32, data width; must match the ALU operand width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction offered this cycle.
- instr_ready  out  1  controller can accept an instruction; high only in IDLE.
- instr  in  32  R-type word: op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0].
- alu_a  out  DW  ALU operand A (registered).
- alu_b  out  DW  ALU operand B (registered).
- alu_sel  out  3  ALU select code (registered).
- alu_result  in  DW  combinational ALU_Out returned by the ALU.
- done  out  1  one-cycle pulse when a result is written back.
- illegal  out  1  one-cycle pulse when an instruction is rejected.
- ld_en  in  1  external register load strobe; honoured only in IDLE.
- ld_addr  in  5  external load address.
- ld_data  in  DW  external load data.
- dbg_addr  in  5  debug read address.
- dbg_data  out  DW  combinational register-file read at dbg_addr.

Behaviour:
- Reset, checked synchronously at the rising edge:
  - state becomes IDLE; all registers are cleared to 0.
  - alu_a, alu_b, alu_sel, done and illegal are driven to 0; instr_ready is 1 in the cycle after reset.
  - Reset overrides any operation in progress: that instruction is aborted with no writeback.
- FSM states: IDLE, DECODE, EXEC, WB, ERR.
- IDLE:
  - instr_ready=1. When instr_valid is also 1, instr is latched and the next state is DECODE.
  - If ld_en=1, ld_data is written to ld_addr. A write to address 0 is dropped.
  - A load and an instruction accept in the same cycle are both performed.
  - The instruction's operand read occurs in DECODE, so it sees the value just loaded.
- DECODE:
  - Illegal when op!=0 or funct is not in the map; next state is ERR.
  - Otherwise the next state is EXEC, with alu_a, alu_b and alu_sel registered at this edge.
  - funct map: 32->000 ADD, 24->001 MUL, 36->010 AND, 37->011 OR, 38->100 XOR, 39->101 NOR, 0->110 SLL, 2->111 SRL.
  - Arithmetic and logic ops: alu_a=R[rs], alu_b=R[rt].
  - Shift ops: alu_a=R[rt], alu_b={27'b0, shamt}.
- EXEC: alu_result is captured into an internal result register; next state is WB.
- WB:
  - result is written to R[rd]; a write to rd=0 is dropped.
  - done=1 for this cycle only; next state is IDLE.
- ERR: illegal=1 for this cycle only; no register write; next state is IDLE.
- Latency: acceptance edge at cycle 0, done high during cycle 3. Throughput is one instruction per 4 cycles (3 for an illegal instruction).
- Width rules:
  - MUL keeps the low 32 bits of the product.
  - ADD wraps modulo 2^32 and there is no overflow trap.
  - SLL/SRL shift by 0..31 from shamt, so there is no over-shift.
- Hazards: none are possible because instructions are serialized. An instruction accepted after done reads the updated register file.
- ld_en outside IDLE is ignored.
- alu_a, alu_b and alu_sel hold their last values outside EXEC.
- dbg_data reads 0 for address 0.

Test Plan:
- Reset, then load R1=5 and R2=7. Issue ADD (op=0, rs=1, rt=2, rd=3, funct=32) -> done in cycle 3, dbg R3=12, alu_sel=000 during EXEC.
- Load R1=0x10000 and R2=0x10000, then MUL rd=4 -> R4=0x00000000 (low 32 bits). Load R2=3, then MUL -> R4=0x30000.
- Load R2=0x80000001, then SLL rd=5, rt=2, shamt=1 -> R5=0x00000002. Then SRL rd=6, rt=2, shamt=31 -> R6=0x00000001, with alu_b=31.
- Issue op=0x23, and separately funct=1 -> illegal pulse 2 cycles after accept, no done, register file unchanged, instr_ready back high next cycle.
- Issue ADD with rd=0 -> done pulses and R0 still reads 0. Hold instr_valid high continuously -> instr_ready is high only in IDLE, and exactly one accept occurs per 4 cycles.
- Assert reset during EXEC of XOR rd=7 -> R7 stays 0, all outputs 0, and instr_ready=1 after reset is released.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake and ALU operand/result bundle between fetch, the issue controller and the ALU.
// master = fetch/ALU side, slave = controller side.
interface alu_issue_ctrl_if #(
  parameter int DW = 32
);
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [2:0]    alu_sel;
  logic [DW-1:0] alu_result;
  logic          done;
  logic          illegal;

  modport master (
    output instr_valid, instr, alu_result,
    input  instr_ready, alu_a, alu_b, alu_sel, done, illegal
  );

  modport slave (
    input  instr_valid, instr, alu_result,
    output instr_ready, alu_a, alu_b, alu_sel, done, illegal
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// R-type issue controller: decode -> operand read -> ALU exec -> writeback; done 3 cycles after accept.
// instr_ready only in IDLE, so one instruction per 4 cycles (3 when rejected as illegal).
module alu_issue_ctrl #(
  parameter int NREGS = 32,
  parameter int DW    = 32
) (
  input  logic                clk,
  input  logic                reset,
  alu_issue_ctrl_if.slave     bus,
  input  logic                ld_en,
  input  logic [4:0]          ld_addr,
  input  logic [DW-1:0]       ld_data,
  input  logic [4:0]          dbg_addr,
  output logic [DW-1:0]       dbg_data
);

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, WB, ERR} state_t;

  state_t        state_q, state_d;
  logic [31:0]   instr_q, instr_d;
  logic [DW-1:0] alu_a_q, alu_a_d;
  logic [DW-1:0] alu_b_q, alu_b_d;
  logic [DW-1:0] result_q, result_d;
  logic [2:0]    alu_sel_q, alu_sel_d;
  logic          done_q, done_d;
  logic          illegal_q, illegal_d;
  logic [DW-1:0] rf_q [NREGS];
  logic [DW-1:0] rf_d [NREGS];

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd, shamt;
  logic       dec_legal, dec_shift;
  logic [2:0] dec_sel;

  assign op    = instr_q[31:26];
  assign rs    = instr_q[25:21];
  assign rt    = instr_q[20:16];
  assign rd    = instr_q[15:11];
  assign shamt = instr_q[10:6];
  assign funct = instr_q[5:0];

  always_comb begin
    dec_legal = (op == 6'd0);
    dec_sel   = 3'd0;
    dec_shift = 1'b0;
    case (funct)
      6'd32:   dec_sel = 3'd0;
      6'd24:   dec_sel = 3'd1;
      6'd36:   dec_sel = 3'd2;
      6'd37:   dec_sel = 3'd3;
      6'd38:   dec_sel = 3'd4;
      6'd39:   dec_sel = 3'd5;
      6'd0:    begin dec_sel = 3'd6; dec_shift = 1'b1; end
      6'd2:    begin dec_sel = 3'd7; dec_shift = 1'b1; end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sel_d = alu_sel_q;
    result_d  = result_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    rf_d      = rf_q;
    case (state_q)
      IDLE: begin
        // Load and accept may coincide; the operand read happens in DECODE and sees the load.
        if (ld_en && ld_addr != 5'd0) rf_d[ld_addr] = ld_data;
        if (bus.instr_valid) begin
          instr_d = bus.instr;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (!dec_legal) begin
          illegal_d = 1'b1;
          state_d   = ERR;
        end else begin
          alu_sel_d = dec_sel;
          if (dec_shift) begin
            alu_a_d = rf_q[rt];
            alu_b_d = {{(DW-5){1'b0}}, shamt};
          end else begin
            alu_a_d = rf_q[rs];
            alu_b_d = rf_q[rt];
          end
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = bus.alu_result;
        done_d   = 1'b1;
        state_d  = WB;
      end
      WB: begin
        if (rd != 5'd0) rf_d[rd] = result_q;
        state_d = IDLE;
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      result_q  <= result_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      rf_q      <= rf_d;
    end
  end

  assign bus.instr_ready = (state_q == IDLE);
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_sel     = alu_sel_q;
  assign bus.done        = done_q;
  assign bus.illegal     = illegal_q;
  assign dbg_data        = (dbg_addr == 5'd0) ? '0 : rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: directed plan plus randomized instructions against a register-file model.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        reset;
  logic        ld_en;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  alu_issue_ctrl_if #(.DW(32)) ifc ();

  alu_issue_ctrl #(.NREGS(32), .DW(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (ifc),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Behavioural 32-bit ALU on the far side of the interface.
  function automatic logic [31:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [2:0] s);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (s)
      3'd0:    return a + b;
      3'd1:    return p[31:0];
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~(a | b);
      3'd6:    return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  always_comb ifc.alu_result = alu_fn(ifc.alu_a, ifc.alu_b, ifc.alu_sel);

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Reference model: architectural register file plus funct table (index = select code).
  logic [31:0] rf_m [32];
  int fmap [8] = '{32, 24, 36, 37, 38, 39, 0, 2};

  typedef struct {
    bit          ill;
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  sel;
  } exp_t;
  exp_t sb [$];

  function automatic logic [31:0] mk(int op, int rs, int rt, int rd, int sh, int f);
    logic [31:0] w;
    w = {op[5:0], rs[4:0], rt[4:0], rd[4:0], sh[4:0], f[5:0]};
    return w;
  endfunction

  function automatic bit m_legal(logic [31:0] w);
    return (w[31:26] == 6'd0) &&
           (w[5:0] inside {6'd32, 6'd24, 6'd36, 6'd37, 6'd38, 6'd39, 6'd0, 6'd2});
  endfunction

  function automatic logic [31:0] m_result(logic [31:0] w);
    logic [31:0] a, b;
    logic [63:0] p;
    a = rf_m[w[25:21]];
    b = rf_m[w[20:16]];
    p = {32'b0, a} * {32'b0, b};
    case (w[5:0])
      6'd32:   return a + b;
      6'd24:   return p[31:0];
      6'd36:   return a & b;
      6'd37:   return a | b;
      6'd38:   return a ^ b;
      6'd39:   return ~(a | b);
      6'd0:    return b << w[10:6];
      default: return b >> w[10:6];
    endcase
  endfunction

  function automatic exp_t m_expect(logic [31:0] w, int c);
    exp_t e;
    e.ill = !m_legal(w);
    e.cyc = c;
    e.a   = '0;
    e.b   = '0;
    e.sel = '0;
    for (int i = 0; i < 8; i++)
      if (fmap[i] == int'(w[5:0])) e.sel = 3'(i);
    if (w[5:0] == 6'd0 || w[5:0] == 6'd2) begin
      e.a = rf_m[w[20:16]];
      e.b = {27'b0, w[10:6]};
    end else begin
      e.a = rf_m[w[25:21]];
      e.b = rf_m[w[20:16]];
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset && (ifc.done || ifc.illegal)) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", {ifc.illegal, ifc.done}, 2'b00);
      end else begin
        e = sb.pop_front();
        chk("resp_kind", {ifc.illegal, ifc.done}, e.ill ? 2'b10 : 2'b01);
        chk("resp_latency", cyc - e.cyc, e.ill ? 2 : 3);
        if (!e.ill) begin
          chk("alu_a", ifc.alu_a, e.a);
          chk("alu_b", ifc.alu_b, e.b);
          chk("alu_sel", ifc.alu_sel, e.sel);
        end
      end
    end
  end

  int last_acc;

  // Called at a negedge; returns at the negedge of the DECODE cycle.
  task automatic issue(input logic [31:0] w, input bit track, input bit hold);
    int n;
    ifc.instr       = w;
    ifc.instr_valid = 1'b1;
    n = 0;
    while (!ifc.instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", ifc.instr_ready, 1'b1);
    last_acc = cyc;
    if (track) begin
      sb.push_back(m_expect(w, cyc));
      if (m_legal(w) && w[15:11] != 5'd0) rf_m[w[15:11]] = m_result(w);
    end
    @(posedge clk);
    @(negedge clk);
    if (!hold) ifc.instr_valid = 1'b0;
    ld_en = 1'b0;
  endtask

  task automatic wait_ready(input int exp_n);
    int n;
    n = 0;
    while (!ifc.instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_return", n, exp_n);
  endtask

  task automatic ld(input int a, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_addr = a[4:0];
    ld_data = d;
    if (a != 0) rf_m[a] = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic chk_reg(input int a);
    dbg_addr = a[4:0];
    #1;
    chk($sformatf("reg_r%0d", a), dbg_data, rf_m[a]);
  endtask

  task automatic run(input logic [31:0] w);
    issue(w, 1'b1, 1'b0);
    wait_ready(m_legal(w) ? 3 : 2);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    int prev, f;
    reset = 1'b1;
    ld_en = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    dbg_addr = '0;
    ifc.instr_valid = 1'b0;
    ifc.instr = '0;
    for (int i = 0; i < 32; i++) rf_m[i] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_ready", ifc.instr_ready, 1'b1);
    chk("rst_outs", {ifc.alu_a, ifc.alu_b, ifc.alu_sel, ifc.done, ifc.illegal}, '0);
    @(negedge clk);
    chk_reg(5);

    // ADD, MUL truncation, shifts
    ld(1, 5); ld(2, 7);
    run(mk(0, 1, 2, 3, 0, 32)); chk_reg(3);
    ld(1, 32'h10000); ld(2, 32'h10000);
    run(mk(0, 1, 2, 4, 0, 24)); chk_reg(4);
    ld(2, 3);
    run(mk(0, 1, 2, 4, 0, 24)); chk_reg(4);
    ld(2, 32'h80000001);
    run(mk(0, 0, 2, 5, 1, 0)); chk_reg(5);
    run(mk(0, 0, 2, 6, 31, 2)); chk_reg(6);

    // Illegal opcode and funct; register file must not change
    run(mk(6'h23, 1, 2, 3, 0, 32));
    run(mk(0, 1, 2, 3, 0, 1));
    for (int i = 0; i < 8; i++) chk_reg(i);

    // rd=0 and load-to-R0 are dropped
    run(mk(0, 1, 2, 0, 0, 32)); chk_reg(0);
    ld(0, 32'hdead_beef); chk_reg(0);

    // Load coinciding with accept feeds the operand read
    ld_en = 1'b1; ld_addr = 5'd1; ld_data = 32'd100; rf_m[1] = 32'd100;
    run(mk(0, 1, 1, 10, 0, 32)); chk_reg(10);

    // Load strobe outside IDLE is ignored
    issue(mk(0, 1, 2, 11, 0, 39), 1'b1, 1'b0);
    ld_en = 1'b1; ld_addr = 5'd9; ld_data = 32'h1234_5678;
    wait_ready(3);
    ld_en = 1'b0;
    chk_reg(9); chk_reg(11);

    // Continuous valid: one accept every 4 cycles
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      w = mk(0, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), fmap[$urandom_range(0, 7)]);
      issue(w, 1'b1, 1'b1);
      if (k > 0) chk("b2b_gap", last_acc - prev, 4);
      prev = last_acc;
    end
    ifc.instr_valid = 1'b0;
    wait_ready(3);

    // Randomized instructions
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0) ld($urandom_range(1, 31), $urandom);
      f = fmap[$urandom_range(0, 7)];
      w = mk(0, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), f);
      case ($urandom_range(0, 7))
        0: w[31:26] = 6'($urandom_range(1, 63));
        1: w[5:0] = 6'd1;
        default: ;
      endcase
      run(w);
      chk_reg(int'(w[15:11]));
    end
    for (int i = 0; i < 32; i++) chk_reg(i);

    // Reset during EXEC aborts the XOR
    ld(3, 32'hf0f0); ld(4, 32'h0ff0);
    issue(mk(0, 3, 4, 7, 0, 38), 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) rf_m[i] = '0;
    #1;
    chk("abort_ready", ifc.instr_ready, 1'b1);
    chk("abort_outs", {ifc.alu_a, ifc.alu_b, ifc.alu_sel, ifc.done, ifc.illegal}, '0);
    repeat (4) @(negedge clk);
    chk_reg(7); chk_reg(3);
    chk("abort_no_resp", {ifc.done, ifc.illegal}, 2'b00);

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
